rr_grant_encoder: RTL and testbench
===================================

Name: rr_grant_encoder

Overview:
- Registered round-robin arbiter. Selects one requester from NUM_REQ request lines and drives both a one-hot grant and its binary index.
- Generalises the combinational one-hot-to-index conversion: adds fairness, grant locking for multi-flit packets, and a valid/ready handshake.
- Used in VC allocation and switch allocation stages, one instance per output port.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- INDEX_SIZE, $clog2(NUM_REQ), width of the index outputs.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request vector; bit i = requester i wants the resource.
- release_grant  input  1  tail/last beat of the current holder; frees the grant when accepted.
- grant_ready  input  1  downstream accepts the current grant beat.
- grant_valid  output  1  a grant is held.
- grant_onehot  output  NUM_REQ  one-hot grant; all-zero when grant_valid=0.
- grant_index  output  INDEX_SIZE  binary index of the holder; 0 when grant_valid=0.
- rr_ptr  output  INDEX_SIZE  current round-robin priority pointer (debug/visibility).

Behaviour:
- Reset (reset=0, async):
  - grant_valid=0, grant_onehot=0, grant_index=0, rr_ptr=0.
  - State goes to IDLE.
  - Reset asserted mid-grant drops the grant immediately; no release is reported.
- States: IDLE, GRANTED.
- IDLE:
  - If req!=0, pick the first set bit at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - Register the pick: grant_valid=1, onehot/index set. Go to GRANTED.
  - Latency is one cycle from req to grant_valid.
  - If req==0, stay in IDLE with outputs zero.
- GRANTED:
  - Grant, onehot and index are held stable while the holder keeps req[grant_index]=1 and no release occurs.
  - Release event = grant_valid & grant_ready & release_grant.
  - Drop event = req[grant_index]==0. This is an abort and needs no handshake.
- On a release or drop:
  - rr_ptr <= (grant_index+1) mod NUM_REQ; wraps from NUM_REQ-1 to 0.
  - In the same cycle, re-arbitrate over req masked to exclude the outgoing holder, starting from the new pointer.
  - If a winner exists, register it and stay in GRANTED. This is a back-to-back grant with no bubble.
  - If no winner exists, go to IDLE.
- The outgoing holder is never re-granted in the cycle it releases, even if it is the only requester. It may win on the next cycle.
- release_grant without grant_ready is ignored and the grant is held.
- release_grant in IDLE is ignored.
- rr_ptr changes only on release or drop. It does not change on the initial grant.
- Invariant: grant_onehot == (grant_valid ? 1<<grant_index : 0).
- Index arithmetic is unsigned, INDEX_SIZE bits. Wrap uses explicit compare-to-(NUM_REQ-1), so non-power-of-2 NUM_REQ works.

Optional Feature:
- Macro: RR_GRANT_PRIO_EN.
- With the macro defined:
  - Extra input prio_req [NUM_REQ].
  - In every arbitration, any set bit of (prio_req & req) is considered first, using the same round-robin search from rr_ptr.
  - Plain req bits are considered only if no priority request exists.
  - Pointer update is unchanged.
- Without the macro:
  - The port is absent; all requests are equal class.

Decomposition:
- Shared package router_pkg holds:
  - localparam function for the wrap-increment of an index;
  - enum typedef arb_state_e {IDLE, GRANTED}.
- One sub-module: rr_pick, purely combinational.
  - Inputs: request vector and start pointer.
  - Outputs: found flag, one-hot and index of the first set bit at or after the pointer with wrap.
  - Instantiated once, or twice when RR_GRANT_PRIO_EN is defined.

Test Plan (NUM_REQ=4):
- Reset then req=4'b0000 for 5 cycles -> grant_valid=0, onehot=0, index=0, rr_ptr=0 throughout.
- req=4'b1010 from IDLE, rr_ptr=0 -> next cycle grant_index=1, onehot=4'b0010. release with ready -> next cycle grant_index=3, rr_ptr=2, no bubble.
- Holder 3 releases with req=4'b1000 only -> next cycle IDLE, rr_ptr=0. Cycle after that -> grant_index=3 again.
- Holder 2 holding, release_grant=1, grant_ready=0 for 3 cycles -> grant held at index 2, rr_ptr unchanged. grant_ready=1 -> released.
- Holder 1 deasserts req[1] mid-packet with req=4'b0001 -> next cycle grant_index=0, rr_ptr=2.
- reset pulsed low while grant_valid=1 -> outputs zero immediately, asynchronously, before the next clk edge. RR_GRANT_PRIO_EN build: req=4'b1111, prio_req=4'b0100 -> grant_index=2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared arbitration types and helpers for the router allocation stages.
package router_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    // Wrap-increment with an explicit compare so non-power-of-2 counts wrap correctly.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick
    import router_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int INDEX_SIZE = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]    req,
    input  logic [INDEX_SIZE-1:0] ptr,
    output logic                  found,
    output logic [NUM_REQ-1:0]    onehot,
    output logic [INDEX_SIZE-1:0] index
);

    logic [INDEX_SIZE-1:0] cand [NUM_REQ];

    // cand[gi] is the requester examined at search distance gi from ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = ((int'(ptr) + gi) >= NUM_REQ)
                            ? INDEX_SIZE'(int'(ptr) + gi - NUM_REQ)
                            : INDEX_SIZE'(int'(ptr) + gi);
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand[k]]) begin
                found = 1'b1;
                index = cand[k];
            end
        end
        if (found) begin
            onehot = NUM_REQ'(1) << index;
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Registered round-robin arbiter with grant locking and release handshake.
// Optional priority class enabled by defining RR_GRANT_PRIO_EN.
module rr_grant_encoder
    import router_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int INDEX_SIZE = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
`ifdef RR_GRANT_PRIO_EN
    input  logic [NUM_REQ-1:0]    prio_req,
`endif
    input  logic                  release_grant,
    input  logic                  grant_ready,
    output logic                  grant_valid,
    output logic [NUM_REQ-1:0]    grant_onehot,
    output logic [INDEX_SIZE-1:0] grant_index,
    output logic [INDEX_SIZE-1:0] rr_ptr
);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    onehot_q, onehot_d;
    logic [INDEX_SIZE-1:0] index_q, index_d;
    logic [INDEX_SIZE-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0]    arb_req;
    logic [INDEX_SIZE-1:0] arb_ptr;
    logic [INDEX_SIZE-1:0] next_ptr;
    logic                  win_found;
    logic [NUM_REQ-1:0]    win_onehot;
    logic [INDEX_SIZE-1:0] win_index;
    logic                  end_ev;

    assign next_ptr = INDEX_SIZE'(wrap_inc(32'(index_q), NUM_REQ));

    // While granted, arbitration looks ahead for the successor: the outgoing holder is excluded.
    assign arb_req = (state_q == GRANTED) ? (req & ~onehot_q) : req;
    assign arb_ptr = (state_q == GRANTED) ? next_ptr : ptr_q;

    logic                  pl_found;
    logic [NUM_REQ-1:0]    pl_onehot;
    logic [INDEX_SIZE-1:0] pl_index;

    rr_pick #(.NUM_REQ(NUM_REQ), .INDEX_SIZE(INDEX_SIZE)) u_pick_plain (
        .req    (arb_req),
        .ptr    (arb_ptr),
        .found  (pl_found),
        .onehot (pl_onehot),
        .index  (pl_index)
    );

`ifdef RR_GRANT_PRIO_EN
    logic                  pr_found;
    logic [NUM_REQ-1:0]    pr_onehot;
    logic [INDEX_SIZE-1:0] pr_index;

    rr_pick #(.NUM_REQ(NUM_REQ), .INDEX_SIZE(INDEX_SIZE)) u_pick_prio (
        .req    (arb_req & prio_req),
        .ptr    (arb_ptr),
        .found  (pr_found),
        .onehot (pr_onehot),
        .index  (pr_index)
    );

    assign win_found  = pr_found | pl_found;
    assign win_onehot = pr_found ? pr_onehot : pl_onehot;
    assign win_index  = pr_found ? pr_index  : pl_index;
`else
    assign win_found  = pl_found;
    assign win_onehot = pl_onehot;
    assign win_index  = pl_index;
`endif

    // A holder dropping its request aborts without needing the handshake.
    assign end_ev = (grant_ready & release_grant) | ~req[index_q];

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        index_d  = index_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = GRANTED;
                    onehot_d = win_onehot;
                    index_d  = win_index;
                end
            end
            GRANTED: begin
                if (end_ev) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        onehot_d = win_onehot;
                        index_d  = win_index;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                        index_d  = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = '0;
                index_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            index_q  <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            index_q  <= index_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant_valid  = (state_q == GRANTED);
    assign grant_onehot = onehot_q;
    assign grant_index  = index_q;
    assign rr_ptr       = ptr_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Self-checking bench for rr_grant_encoder: reference model plus directed literal checks.
module tb_rr_grant_encoder;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  prio = '0;
    logic          release_grant = 1'b0;
    logic          grant_ready = 1'b0;
    logic          grant_valid;
    logic [N-1:0]  grant_onehot;
    logic [IW-1:0] grant_index;
    logic [IW-1:0] rr_ptr;

    int checks = 0;
    int failures = 0;

    rr_grant_encoder #(.NUM_REQ(N), .INDEX_SIZE(IW)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .req           (req),
`ifdef RR_GRANT_PRIO_EN
        .prio_req      (prio),
`endif
        .release_grant (release_grant),
        .grant_ready   (grant_ready),
        .grant_valid   (grant_valid),
        .grant_onehot  (grant_onehot),
        .grant_index   (grant_index),
        .rr_ptr        (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Spec-level pick: priority class first, then plain, both searched from start with wrap.
    function automatic int arb(input logic [N-1:0] r, input logic [N-1:0] p,
                               input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && r[i] && p[i]) return i;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    logic [N-1:0] eff_prio;
`ifdef RR_GRANT_PRIO_EN
    assign eff_prio = prio;
`else
    assign eff_prio = '0;
`endif

    int m_valid, m_idx, m_ptr;
    int nx_valid, nx_idx, nx_ptr, w;

    always_comb begin
        nx_valid = m_valid;
        nx_idx   = m_idx;
        nx_ptr   = m_ptr;
        w        = -1;
        if (m_valid == 0) begin
            w = arb(req, eff_prio, m_ptr, -1);
            if (w >= 0) begin
                nx_valid = 1;
                nx_idx   = w;
            end
        end else if ((grant_ready && release_grant) || !req[m_idx]) begin
            nx_ptr = (m_idx + 1) % N;
            w = arb(req, eff_prio, nx_ptr, m_idx);
            if (w >= 0) begin
                nx_idx = w;
            end else begin
                nx_valid = 0;
                nx_idx   = 0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0;
            m_idx   <= 0;
            m_ptr   <= 0;
        end else begin
            m_valid <= nx_valid;
            m_idx   <= nx_idx;
            m_ptr   <= nx_ptr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid",  int'(grant_valid),  m_valid);
            chk("model_onehot", int'(grant_onehot), (m_valid != 0) ? (1 << m_idx) : 0);
            chk("model_index",  int'(grant_index),  m_idx);
            chk("model_rr_ptr", int'(rr_ptr),       m_ptr);
        end
    end

    // Drive one transaction at the falling edge and sample just after the next rising edge.
    task automatic apply(input logic [N-1:0] r, input logic rel, input logic rdy);
        @(negedge clk);
        req = r;
        release_grant = rel;
        grant_ready = rdy;
        @(posedge clk);
        #1;
        $display("txn req=%b prio=%b rel=%0d rdy=%0d -> valid=%0d onehot=%b index=%0d rr_ptr=%0d",
                 r, prio, rel, rdy, grant_valid, grant_onehot, grant_index, rr_ptr);
    endtask

    task automatic expect_grant(input string nm, input int v, input int idx, input int ptr);
        chk({nm, "_valid"},  int'(grant_valid),  v);
        chk({nm, "_onehot"}, int'(grant_onehot), (v != 0) ? (1 << idx) : 0);
        chk({nm, "_index"},  int'(grant_index),  idx);
        chk({nm, "_rr_ptr"}, int'(rr_ptr),       ptr);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        expect_grant("in_reset", 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply(4'b0000, 1'b0, 1'b0);
            expect_grant("idle_no_req", 0, 0, 0);
        end

        apply(4'b1010, 1'b0, 1'b0);
        expect_grant("first_grant", 1, 1, 0);
        apply(4'b1010, 1'b1, 1'b1);
        expect_grant("b2b_grant", 1, 3, 2);

        apply(4'b1000, 1'b1, 1'b1);
        expect_grant("sole_release_idle", 0, 0, 0);
        apply(4'b1000, 1'b0, 1'b0);
        expect_grant("regrant_next", 1, 3, 0);

        apply(4'b0100, 1'b0, 1'b0);
        expect_grant("drop_to_2", 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            apply(4'b0100, 1'b1, 1'b0);
            expect_grant("rel_no_ready_hold", 1, 2, 0);
        end
        apply(4'b0100, 1'b1, 1'b1);
        expect_grant("rel_with_ready", 0, 0, 3);

        apply(4'b0010, 1'b0, 1'b0);
        expect_grant("grant_1_wrap_search", 1, 1, 3);
        apply(4'b0001, 1'b0, 1'b0);
        expect_grant("drop_mid_packet", 1, 0, 2);

        apply(4'b0001, 1'b1, 1'b1);
        expect_grant("release_0", 0, 0, 1);
        apply(4'b0000, 1'b1, 1'b1);
        expect_grant("release_in_idle", 0, 0, 1);

        apply(4'b1111, 1'b0, 1'b0);
        expect_grant("all_req", 1, 1, 1);
        apply(4'b1111, 1'b1, 1'b1);
        expect_grant("rr_step_a", 1, 2, 2);
        apply(4'b1111, 1'b1, 1'b1);
        expect_grant("rr_step_b", 1, 3, 3);
        apply(4'b1111, 1'b1, 1'b1);
        expect_grant("rr_wrap", 1, 0, 0);
        apply(4'b1111, 1'b1, 1'b1);
        expect_grant("rr_step_c", 1, 1, 1);

        // Asynchronous reset mid-grant, checked before the next rising edge.
        @(negedge clk);
        release_grant = 1'b0;
        grant_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_grant("async_reset", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1111, 1'b0, 1'b0);
        expect_grant("after_reset", 1, 0, 0);

`ifdef RR_GRANT_PRIO_EN
        apply(4'b0000, 1'b0, 1'b0);
        expect_grant("prio_setup_idle", 0, 0, 1);
        prio = 4'b0100;
        apply(4'b1111, 1'b0, 1'b0);
        expect_grant("prio_first", 1, 2, 1);
        prio = 4'b0101;
        apply(4'b1111, 1'b1, 1'b1);
        expect_grant("prio_rr", 1, 0, 3);
        prio = 4'b0000;
`endif

        for (int i = 0; i < 150; i++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, (1 << N) - 1));
`ifdef RR_GRANT_PRIO_EN
            prio = N'($urandom_range(0, (1 << N) - 1));
`endif
            apply(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
